// File: rtl/arith_mult_cst_goldilocks_inv_pkg.sv
// rtl/arith_mult_cst_goldilocks_inv_pkg.sv - shared latency and CSD recoding helpers for constant multipliers
package arith_mult_cst_goldilocks_inv_pkg;

    localparam int MAX_CSD_TERMS = 4;
    localparam int CSD_MAX_W     = 256;

    // count holds the full digit count so callers can reject constants with too many digits.
    typedef struct packed {
        logic [15:0]                          count;
        logic [MAX_CSD_TERMS-1:0][15:0]       exp;
        logic [MAX_CSD_TERMS-1:0]             neg;
    } csd_t;

    function automatic int get_latency();
        return 2;
    endfunction

    function automatic csd_t csd_recode(input logic [CSD_MAX_W-1:0] cst);
        csd_t                 r;
        logic [CSD_MAX_W:0]   c;
        r = '0;
        c = {1'b0, cst};
        for (int k = 0; k <= CSD_MAX_W; k++) begin
            if (c[0]) begin
                if (int'(r.count) < MAX_CSD_TERMS) begin
                    r.exp[r.count[1:0]] = 16'(k);
                    r.neg[r.count[1:0]] = c[1];
                end
                r.count = r.count + 16'd1;
                // A run of ones ending here becomes a -1 digit with a carry into the run.
                if (c[1]) c = c + 1'b1;
                else      c = c - 1'b1;
            end
            c = c >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_cst_avail_side_pipe.sv
// rtl/mult_cst_avail_side_pipe.sv - avail/side-band delay line matching a constant multiplier's latency
module mult_cst_avail_side_pipe #(
    parameter int         DEPTH    = 3,
    parameter int         SIDE_W   = 8,
    parameter logic [1:0] RST_SIDE = 2'b00
) (
    input  logic              clk,
    input  logic              a_rst,
    input  logic              in_avail,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_avail,
    output logic [SIDE_W-1:0] out_side
);

    logic [DEPTH-1:0]  avail_q;
    logic [DEPTH-1:0]  avail_d;
    logic [SIDE_W-1:0] side_q [DEPTH];

    assign avail_d = DEPTH'({avail_q, in_avail});

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) avail_q <= '0;
        else       avail_q <= avail_d;
    end

    if (RST_SIDE == 2'b00) begin : g_side_noreset
        always_ff @(posedge clk) begin
            side_q[0] <= in_side;
            for (int i = 1; i < DEPTH; i++) side_q[i] <= side_q[i-1];
        end
    end else begin : g_side_reset
        localparam logic [SIDE_W-1:0] SIDE_RST = (RST_SIDE == 2'b10) ? '1 : '0;
        always_ff @(posedge clk or posedge a_rst) begin
            if (a_rst) begin
                for (int i = 0; i < DEPTH; i++) side_q[i] <= SIDE_RST;
            end else begin
                side_q[0] <= in_side;
                for (int i = 1; i < DEPTH; i++) side_q[i] <= side_q[i-1];
            end
        end
    end

    assign out_avail = avail_q[DEPTH-1];
    assign out_side  = side_q[DEPTH-1];

endmodule

// File: rtl/mult_cst_goldilocks_inv.sv
// rtl/mult_cst_goldilocks_inv.sv - pipelined multiply by an elaboration-time constant via CSD shift-add
module mult_cst_goldilocks_inv
    import arith_mult_cst_goldilocks_inv_pkg::*;
#(
    parameter int                IN_PIPE  = 1,
    parameter int                IN_W     = 8,
    parameter int                CST_W    = 97,
    parameter logic [CST_W-1:0]  CST      = CST_W'((97'd1 << 96) + (97'd1 << 64) - 97'd2),
    parameter int                SIDE_W   = 8,
    parameter logic [1:0]        RST_SIDE = 2'b00
) (
    input  logic                    clk,
    input  logic                    a_rst,
    input  logic [IN_W-1:0]         a,
    input  logic                    in_avail,
    input  logic [SIDE_W-1:0]       in_side,
    output logic [IN_W+CST_W-1:0]   z,
    output logic                    out_avail,
    output logic [SIDE_W-1:0]       out_side
);

    localparam int   LAT = get_latency() + IN_PIPE;
    localparam int   W   = IN_W + CST_W + 2;
    localparam int   ZW  = IN_W + CST_W;
    localparam csd_t CSD = csd_recode(CSD_MAX_W'(CST));

    if (CST_W > CSD_MAX_W) begin : g_width_check
        $fatal(1, "CST_W %0d exceeds recoder width %0d", CST_W, CSD_MAX_W);
    end
    if (int'(CSD.count) > MAX_CSD_TERMS) begin : g_csd_check
        $fatal(1, "CST has %0d CSD digits, at most %0d supported", CSD.count, MAX_CSD_TERMS);
    end

    logic [IN_W-1:0] a_s;

    if (IN_PIPE != 0) begin : g_in_pipe
        logic [IN_W-1:0] a_q;
        always_ff @(posedge clk) a_q <= a;
        assign a_s = a_q;
    end else begin : g_in_direct
        assign a_s = a;
    end

    logic signed [W-1:0] a_ext;
    logic signed [W-1:0] term [MAX_CSD_TERMS];

    assign a_ext = $signed({{(W-IN_W){1'b0}}, a_s});

    for (genvar i = 0; i < MAX_CSD_TERMS; i++) begin : g_term
        localparam int K = int'(CSD.exp[i]);
        if (i < int'(CSD.count)) begin : g_used
            if (CSD.neg[i]) begin : g_neg
                assign term[i] = -(a_ext <<< K);
            end else begin : g_pos
                assign term[i] = a_ext <<< K;
            end
        end else begin : g_absent
            assign term[i] = '0;
        end
    end

    logic signed [W-1:0] p0_d, p1_d, p0_q, p1_q;
    logic [ZW-1:0]       z_d, z_q;

    assign p0_d = term[0] + term[1];
    assign p1_d = term[2] + term[3];
    // The sum is non-negative by construction, so the low bits are the exact product.
    assign z_d  = ZW'(p0_q + p1_q);

    always_ff @(posedge clk) begin
        p0_q <= p0_d;
        p1_q <= p1_d;
        z_q  <= z_d;
    end

    assign z = z_q;

    mult_cst_avail_side_pipe #(
        .DEPTH    (LAT),
        .SIDE_W   (SIDE_W),
        .RST_SIDE (RST_SIDE)
    ) u_avail_side_pipe (
        .clk       (clk),
        .a_rst     (a_rst),
        .in_avail  (in_avail),
        .in_side   (in_side),
        .out_avail (out_avail),
        .out_side  (out_side)
    );

endmodule

// File: tb/tb_mult_cst_goldilocks_inv.sv
// tb/tb_mult_cst_goldilocks_inv.sv - directed and random checks of the constant multiplier
module tb_mult_cst_goldilocks_inv;

    localparam logic [96:0] CST0 = (97'd1 << 96) + (97'd1 << 64) - 97'd2;
    localparam logic [64:0] CST1 = 65'hFFFF_FFFF_0000_0001;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   a;
    logic         in_avail;
    logic [7:0]   in_side;
    logic [104:0] z0;
    logic         av0;
    logic [7:0]   side0;
    logic [72:0]  z1;
    logic         av1;
    logic [7:0]   side1;

    int n_checks = 0;
    int n_fail   = 0;

    logic       h_av [0:3];
    logic [7:0] h_a  [0:3];
    logic [7:0] h_s  [0:3];

    always #5 clk = ~clk;

    mult_cst_goldilocks_inv u_dut0 (
        .clk       (clk),
        .a_rst     (rst),
        .a         (a),
        .in_avail  (in_avail),
        .in_side   (in_side),
        .z         (z0),
        .out_avail (av0),
        .out_side  (side0)
    );

    mult_cst_goldilocks_inv #(
        .IN_PIPE  (0),
        .IN_W     (8),
        .CST_W    (65),
        .CST      (CST1),
        .SIDE_W   (8),
        .RST_SIDE (2'b01)
    ) u_dut1 (
        .clk       (clk),
        .a_rst     (rst),
        .a         (a),
        .in_avail  (in_avail),
        .in_side   (in_side),
        .z         (z1),
        .out_avail (av1),
        .out_side  (side1)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then compare both DUTs against the delayed input history.
    task automatic cycle(input logic av, input logic [7:0] ai, input logic [7:0] si);
        logic [104:0] e0;
        logic [72:0]  e1;
        in_avail = av;
        a        = ai;
        in_side  = si;
        @(posedge clk);
        for (int i = 3; i > 0; i--) begin
            h_av[i] = h_av[i-1];
            h_a[i]  = h_a[i-1];
            h_s[i]  = h_s[i-1];
        end
        h_av[0] = av;
        h_a[0]  = ai;
        h_s[0]  = si;
        @(negedge clk);
        check("avail_lat3", 128'(av0), 128'(h_av[2]));
        if (h_av[2]) begin
            e0 = {97'd0, h_a[2]} * {8'd0, CST0};
            check("z_lat3", 128'(z0), 128'(e0));
            check("side_lat3", 128'(side0), 128'(h_s[2]));
        end
        check("avail_lat2", 128'(av1), 128'(h_av[1]));
        if (h_av[1]) begin
            e1 = {65'd0, h_a[1]} * {8'd0, CST1};
            check("z_lat2", 128'(z1), 128'(e1));
            check("side_lat2", 128'(side1), 128'(h_s[1]));
        end
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 4; i++) begin
            h_av[i] = 1'b0;
            h_a[i]  = '0;
            h_s[i]  = '0;
        end
    endtask

    initial begin
        clear_hist();
        rst      = 1'b1;
        a        = '0;
        in_avail = 1'b0;
        in_side  = '0;
        repeat (3) @(negedge clk);
        check("reset_avail0", 128'(av0), 128'd0);
        check("reset_avail1", 128'(av1), 128'd0);
        check("reset_side1", 128'(side1), 128'd0);
        rst = 1'b0;

        cycle(1'b1, 8'd1, 8'h5A);
        cycle(1'b0, 8'd0, 8'h00);
        check("one_z_cst1", 128'(z1), 128'h0_FFFF_FFFF_0000_0001);
        check("one_side_cst1", 128'(side1), 128'h5A);
        cycle(1'b0, 8'd0, 8'h00);
        check("one_z_cst0", 128'(z0), 128'h1_0000_0000_FFFF_FFFF_FFFF_FFFE);
        check("one_side_cst0", 128'(side0), 128'h5A);
        check("one_avail_cst0", 128'(av0), 128'd1);
        repeat (3) cycle(1'b0, 8'd0, 8'h00);

        cycle(1'b1, 8'd0, 8'h11);
        cycle(1'b0, 8'd0, 8'h00);
        cycle(1'b0, 8'd0, 8'h00);
        check("zero_z_cst0", 128'(z0), 128'd0);

        cycle(1'b1, 8'h80, 8'h22);
        cycle(1'b1, 8'hFF, 8'h33);
        check("x80_z_cst1", 128'(z1), 128'h7F_FFFF_FF80_0000_0080);
        cycle(1'b0, 8'd0, 8'h00);
        check("xff_z_cst1", 128'(z1), 128'hFE_FFFF_FF01_0000_00FF);
        cycle(1'b0, 8'd0, 8'h00);
        check("xff_z_cst0", 128'(z0), 128'hFF_0000_00FE_FFFF_FFFF_FFFF_FE02);
        check("xff_side_cst0", 128'(side0), 128'h33);
        repeat (3) cycle(1'b0, 8'd0, 8'h00);

        for (int n = 0; n < 2000; n++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
        end

        cycle(1'b1, 8'h0A, 8'hA1);
        cycle(1'b1, 8'h0B, 8'hA2);
        cycle(1'b1, 8'h0C, 8'hA3);
        in_avail = 1'b0;
        rst      = 1'b1;
        #1;
        check("midrst_avail0", 128'(av0), 128'd0);
        check("midrst_avail1", 128'(av1), 128'd0);
        check("midrst_side1", 128'(side1), 128'd0);
        clear_hist();
        @(posedge clk);
        @(negedge clk);
        check("inrst_avail0", 128'(av0), 128'd0);
        check("inrst_side1", 128'(side1), 128'd0);
        rst = 1'b0;
        repeat (5) cycle(1'b0, 8'd0, 8'h00);
        cycle(1'b1, 8'h03, 8'h77);
        cycle(1'b1, 8'hC4, 8'h78);
        repeat (4) cycle(1'b0, 8'd0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
